hazard_ctrl: RTL and testbench

- Parametrised pipeline hazard controller for the 5-stage MIPS datapath; successor to the combinational stall detector.
- Detects RAW hazards between ID source registers and EX/MEM destinations. With forwarding enabled, only load-use hazards stall; with forwarding disabled, every in-flight writer stalls.
- Adds a multi-cycle multiply/divide (MDU) busy tracker, taken-branch flush, and a saturating stall-cycle counter for performance measurement.

---
 rtl/hazard_ctrl.sv | 101 ++++++++++
 tb/tb_hazard_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: RAW stall detection,
// MDU busy tracking, taken-branch flush and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int FORWARD_EN = 1,
  parameter int MDU_LAT    = 4,
  parameter int CNT_W      = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [REG_AW-1:0] ID_Rs,
  input  logic [REG_AW-1:0] ID_Rt,
  input  logic              ID_UsesRs,
  input  logic              ID_UsesRt,
  input  logic              ID_IsMDU,
  input  logic              ID_ReadsHiLo,
  input  logic [REG_AW-1:0] EX_Dest,
  input  logic              EX_RegWrite,
  input  logic              EX_MemRead,
  input  logic [REG_AW-1:0] MEM_Dest,
  input  logic              MEM_RegWrite,
  input  logic              Branch_Taken,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic              HazardMux,
  output logic              IFIDFlush,
  output logic              MDUBusy,
  output logic [CNT_W-1:0]  StallCount
);

  localparam logic [3:0] MduLat = 4'(MDU_LAT);

  logic [3:0]       mduCnt;
  logic [CNT_W-1:0] stallCnt;
  logic             exHit;
  logic             memHit;
  logic             dataStall;
  logic             mduStall;
  logic             stall;
  logic             issue;

  // Register 0 is hard-wired, so it can never carry a real dependency.
  function automatic logic srcMatch(input logic uses,
                                    input logic [REG_AW-1:0] src,
                                    input logic [REG_AW-1:0] dest);
    return uses && (src != '0) && (src == dest);
  endfunction

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign exHit  = EX_RegWrite &
                  (srcMatch(ID_UsesRs, ID_Rs, EX_Dest) | srcMatch(ID_UsesRt, ID_Rt, EX_Dest));
  assign memHit = MEM_RegWrite &
                  (srcMatch(ID_UsesRs, ID_Rs, MEM_Dest) | srcMatch(ID_UsesRt, ID_Rt, MEM_Dest));

  // With forwarding only a load in EX cannot be bypassed in time.
  assign dataStall = (FORWARD_EN != 0) ? (exHit & EX_MemRead) : (exHit | memHit);
  assign MDUBusy   = (mduCnt != 4'd0);
  assign mduStall  = MDUBusy & (ID_ReadsHiLo | ID_IsMDU);
  assign stall     = (dataStall | mduStall) & ~Branch_Taken;
  assign issue     = ID_IsMDU & ~stall & ~Branch_Taken;

  always_comb begin
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    HazardMux = 1'b0;
    IFIDFlush = 1'b0;
    if (Branch_Taken) begin
      HazardMux = 1'b1;
      IFIDFlush = 1'b1;
    end else if (stall) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      HazardMux = 1'b1;
    end
  end

  // A fresh issue reloads the latency even if the counter is still running.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mduCnt <= 4'd0;
    end else if (issue) begin
      mduCnt <= MduLat;
    end else if (MDUBusy) begin
      mduCnt <= mduCnt - 4'd1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stallCnt <= '0;
    end else if (stall) begin
      stallCnt <= satInc(stallCnt);
    end
  end

  assign StallCount = stallCnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: one forwarding instance (16-bit counter) and one
// non-forwarding instance (4-bit counter) share the same stimulus.
module tb_hazard_ctrl;
  localparam int AW  = 5;
  localparam int LAT = 4;
  localparam int MAXF = 65535;
  localparam int MAXN = 15;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic [AW-1:0] ID_Rs, ID_Rt, EX_Dest, MEM_Dest;
  logic          ID_UsesRs, ID_UsesRt, ID_IsMDU, ID_ReadsHiLo;
  logic          EX_RegWrite, EX_MemRead, MEM_RegWrite, Branch_Taken;

  logic        pcwF, ifwF, hmF, flF, busyF;
  logic [15:0] cntFo;
  logic        pcwN, ifwN, hmN, flN, busyN;
  logic [3:0]  cntNo;

  hazard_ctrl #(.REG_AW(AW), .FORWARD_EN(1), .MDU_LAT(LAT), .CNT_W(16)) u_fwd (
    .Clk(Clk), .Rst_n(Rst_n), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_IsMDU(ID_IsMDU),
    .ID_ReadsHiLo(ID_ReadsHiLo), .EX_Dest(EX_Dest), .EX_RegWrite(EX_RegWrite),
    .EX_MemRead(EX_MemRead), .MEM_Dest(MEM_Dest), .MEM_RegWrite(MEM_RegWrite),
    .Branch_Taken(Branch_Taken), .PCWrite(pcwF), .IFIDWrite(ifwF),
    .HazardMux(hmF), .IFIDFlush(flF), .MDUBusy(busyF), .StallCount(cntFo));

  hazard_ctrl #(.REG_AW(AW), .FORWARD_EN(0), .MDU_LAT(LAT), .CNT_W(4)) u_nofwd (
    .Clk(Clk), .Rst_n(Rst_n), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_IsMDU(ID_IsMDU),
    .ID_ReadsHiLo(ID_ReadsHiLo), .EX_Dest(EX_Dest), .EX_RegWrite(EX_RegWrite),
    .EX_MemRead(EX_MemRead), .MEM_Dest(MEM_Dest), .MEM_RegWrite(MEM_RegWrite),
    .Branch_Taken(Branch_Taken), .PCWrite(pcwN), .IFIDWrite(ifwN),
    .HazardMux(hmN), .IFIDFlush(flN), .MDUBusy(busyN), .StallCount(cntNo));

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int remF, remN, cntF, cntN;

  typedef struct {
    logic [AW-1:0] rs, rt;
    logic          uRs, uRt;
    logic [AW-1:0] exD;
    logic          exRW, exMR;
    logic [AW-1:0] memD;
    logic          memRW, br;
    logic [3:0]    expF, expN;   // {PCWrite, IFIDWrite, HazardMux, IFIDFlush}
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit modelStall(input bit fwd, input int rem);
    bit rsOk, rtOk, exHit, memHit, dataS, mduS;
    rsOk   = ID_UsesRs && ID_Rs != 0;
    rtOk   = ID_UsesRt && ID_Rt != 0;
    exHit  = EX_RegWrite && ((rsOk && ID_Rs == EX_Dest) || (rtOk && ID_Rt == EX_Dest));
    memHit = MEM_RegWrite && ((rsOk && ID_Rs == MEM_Dest) || (rtOk && ID_Rt == MEM_Dest));
    dataS  = fwd ? (exHit && EX_MemRead) : (exHit || memHit);
    mduS   = rem > 0 && (ID_ReadsHiLo || ID_IsMDU);
    return (dataS || mduS) && !Branch_Taken;
  endfunction

  function automatic logic [3:0] expOut(input bit st);
    if (Branch_Taken) return 4'b1111;
    if (st) return 4'b0010;
    return 4'b1100;
  endfunction

  // Compare both instances against the model, then advance one clock.
  task automatic cycle(input string tag);
    bit sF, sN;
    #1;
    sF = modelStall(1'b1, remF);
    sN = modelStall(1'b0, remN);
    chk({tag, " outF"}, {pcwF, ifwF, hmF, flF}, expOut(sF));
    chk({tag, " outN"}, {pcwN, ifwN, hmN, flN}, expOut(sN));
    chk({tag, " busyF"}, busyF, remF > 0);
    chk({tag, " busyN"}, busyN, remN > 0);
    chk({tag, " cntF"}, cntFo, cntF);
    chk({tag, " cntN"}, cntNo, cntN);
    @(posedge Clk);
    if (ID_IsMDU && !sF && !Branch_Taken) remF = LAT; else if (remF > 0) remF--;
    if (ID_IsMDU && !sN && !Branch_Taken) remN = LAT; else if (remN > 0) remN--;
    if (sF && cntF < MAXF) cntF++;
    if (sN && cntN < MAXN) cntN++;
    @(negedge Clk);
  endtask

  task automatic clearIn();
    ID_Rs = '0; ID_Rt = '0; ID_UsesRs = 0; ID_UsesRt = 0; ID_IsMDU = 0;
    ID_ReadsHiLo = 0; EX_Dest = '0; EX_RegWrite = 0; EX_MemRead = 0;
    MEM_Dest = '0; MEM_RegWrite = 0; Branch_Taken = 0;
  endtask

  task automatic loadUse();
    clearIn();
    ID_Rs = 5'd3; ID_UsesRs = 1; EX_Dest = 5'd3; EX_RegWrite = 1; EX_MemRead = 1;
  endtask

  initial begin
    logic [15:0] c0;
    tbl[0] = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 4'b1100, 4'b1100};
    tbl[1] = '{5'd3, 5'd0, 1, 0, 5'd3, 1, 1, 5'd0, 0, 0, 4'b0010, 4'b0010};
    tbl[2] = '{5'd3, 5'd0, 1, 0, 5'd3, 1, 0, 5'd0, 0, 0, 4'b1100, 4'b0010};
    tbl[3] = '{5'd0, 5'd7, 0, 1, 5'd0, 0, 0, 5'd7, 1, 0, 4'b1100, 4'b0010};
    tbl[4] = '{5'd0, 5'd0, 1, 0, 5'd0, 1, 1, 5'd0, 1, 0, 4'b1100, 4'b1100};
    tbl[5] = '{5'd3, 5'd0, 0, 0, 5'd3, 1, 1, 5'd0, 0, 0, 4'b1100, 4'b1100};
    tbl[6] = '{5'd3, 5'd0, 1, 0, 5'd3, 1, 1, 5'd0, 0, 1, 4'b1111, 4'b1111};
    tbl[7] = '{5'd0, 5'd5, 0, 1, 5'd5, 0, 1, 5'd0, 0, 0, 4'b1100, 4'b1100};
    tbl[8] = '{5'd4, 5'd0, 1, 0, 5'd0, 0, 0, 5'd4, 0, 0, 4'b1100, 4'b1100};
    tbl[9] = '{5'd0, 5'd9, 0, 1, 5'd9, 1, 1, 5'd0, 0, 0, 4'b0010, 4'b0010};

    clearIn();
    Rst_n = 0;
    remF = 0; remN = 0; cntF = 0; cntN = 0;
    @(negedge Clk);
    chk("rst outF", {pcwF, ifwF, hmF, flF}, 4'b1100);
    chk("rst busyF", busyF, 0);
    chk("rst cntF", cntFo, 0);
    chk("rst cntN", cntNo, 0);
    Rst_n = 1;
    @(negedge Clk);

    for (int i = 0; i < 10; i++) begin
      clearIn();
      ID_Rs = tbl[i].rs; ID_Rt = tbl[i].rt; ID_UsesRs = tbl[i].uRs; ID_UsesRt = tbl[i].uRt;
      EX_Dest = tbl[i].exD; EX_RegWrite = tbl[i].exRW; EX_MemRead = tbl[i].exMR;
      MEM_Dest = tbl[i].memD; MEM_RegWrite = tbl[i].memRW; Branch_Taken = tbl[i].br;
      #1;
      chk($sformatf("tbl%0d F", i), {pcwF, ifwF, hmF, flF}, tbl[i].expF);
      chk($sformatf("tbl%0d N", i), {pcwN, ifwN, hmN, flN}, tbl[i].expN);
      cycle("tblModel");
    end

    // mult at t, mfhi at t+1: four bubble cycles, release at t+5.
    clearIn();
    ID_IsMDU = 1;
    cycle("mduIssue");
    c0 = cntFo;
    ID_IsMDU = 0; ID_ReadsHiLo = 1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("mfhiHold", hmF, 1);
      chk("mfhiBusy", busyF, 1);
      cycle("mfhi");
    end
    #1;
    chk("mfhiRelease hm", hmF, 0);
    chk("mfhiRelease busy", busyF, 0);
    chk("mfhiStalls", cntFo - c0, 4);
    cycle("mfhiGo");

    // Load-use under a taken branch: flush wins, no count.
    loadUse();
    Branch_Taken = 1;
    #1;
    chk("brFlush fl", flF, 1);
    chk("brFlush pcw", pcwF, 1);
    chk("brFlush hm", hmF, 1);
    c0 = cntFo;
    cycle("brFlush");
    chk("brFlush cnt", cntFo, c0);

    // Asynchronous reset with the MDU counter at 2.
    clearIn();
    ID_IsMDU = 1;
    cycle("mduIssue2");
    ID_IsMDU = 0;
    cycle("mduRun");
    cycle("mduRun");
    #2;
    chk("preRst busy", busyF, 1);
    Rst_n = 0;
    #1;
    chk("asyncRst busyF", busyF, 0);
    chk("asyncRst busyN", busyN, 0);
    chk("asyncRst cntF", cntFo, 0);
    chk("asyncRst cntN", cntNo, 0);
    chk("asyncRst out", {pcwF, ifwF, hmF, flF}, 4'b1100);
    remF = 0; remN = 0; cntF = 0; cntN = 0;
    @(negedge Clk);
    Rst_n = 1;

    // 20 load-use stalls: 4-bit counter pins at 15.
    loadUse();
    repeat (20) cycle("sat");
    chk("satN", cntNo, 15);
    chk("satF", cntFo, 20);

    for (int i = 0; i < 400; i++) begin
      ID_Rs = AW'($urandom_range(0, 3));
      ID_Rt = AW'($urandom_range(0, 3));
      ID_UsesRs = 1'($urandom);
      ID_UsesRt = 1'($urandom);
      ID_IsMDU = ($urandom_range(0, 3) == 0);
      ID_ReadsHiLo = ($urandom_range(0, 3) == 0);
      EX_Dest = AW'($urandom_range(0, 3));
      EX_RegWrite = 1'($urandom);
      EX_MemRead = 1'($urandom);
      MEM_Dest = AW'($urandom_range(0, 3));
      MEM_RegWrite = 1'($urandom);
      Branch_Taken = ($urandom_range(0, 7) == 0);
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
